// File: rtl/sram_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sram_pkg
// Purpose  : Shared constants for the SRAM bus, used by sram_emu and
//            sram_control. Provides default bus widths, the FSM state
//            encoding of the SRAM responder, the latency counter width and
//            the DQ tri-state enable convention.
// Revision : 1.0 - initial release
// ============================================================================
package sram_pkg;

    // Default bus geometry
    localparam int c_DEF_DATA_SIZE = 8;
    localparam int c_DEF_ADDR_SIZE = 19;
    localparam int c_DEF_MEM_ADDR  = 12;
    localparam int c_DEF_READ_LAT  = 2;

    // Read latency counter holds READ_LAT-1, READ_LAT is limited to 1..7
    localparam int c_LAT_W = 3;

    // Responder state encoding
    localparam int             c_ST_W          = 2;
    localparam logic [c_ST_W-1:0] c_ST_IDLE       = 2'd0;
    localparam logic [c_ST_W-1:0] c_ST_WRITE_ACT  = 2'd1;
    localparam logic [c_ST_W-1:0] c_ST_READ_WAIT  = 2'd2;
    localparam logic [c_ST_W-1:0] c_ST_READ_DRIVE = 2'd3;

    // DQ output enable convention: enable high means this end drives DQ
    localparam logic c_DQ_DRIVE   = 1'b1;
    localparam logic c_DQ_RELEASE = 1'b0;

endpackage : sram_pkg
`default_nettype wire

// File: rtl/sram_emu_mem.sv
`default_nettype none
// ============================================================================
// Module   : sram_emu_mem
// Purpose  : Single-port synchronous RAM, write-first, for block RAM
//            inference. Contents are never cleared.
// Ports    : clk      - clock
//            i_we     - write enable
//            i_addr   - word address
//            i_wdata  - write data
//            o_rdata  - registered read data (new data on a write)
// Revision : 1.0 - initial release
// ============================================================================
module sram_emu_mem #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
            r_rdata       <= i_wdata;
        end else begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule : sram_emu_mem
`default_nettype wire

// File: rtl/sram_emu.sv
`default_nettype none
// ============================================================================
// Module   : sram_emu
// Purpose  : Device end of an asynchronous SRAM bus, emulated with on-chip
//            block RAM and sampled on clk. Adds read-path fault injection
//            and write/read access counters.
// Ports    : clk, rst               - clock, synchronous active-high reset
//            SRAM_DQ                - bidirectional data, driven only while
//                                     serving a read
//            SRAM_ADDR              - address (upper bits alias)
//            SRAM_CE_N/OE_N/WE_N    - active-low controls
//            SRAM_UB_N/LB_N         - byte lanes, ignored on an 8-bit bus
//            fault_en/addr/mask     - XOR mask on reads of one location
//            wr_count, rd_count     - committed writes / served reads
//            busy                   - FSM not idle
// Revision : 1.0 - initial release
// ============================================================================
module sram_emu
    import sram_pkg::*;
#(
    parameter int SRAM_DATA_SIZE = c_DEF_DATA_SIZE,
    parameter int SRAM_ADDR_SIZE = c_DEF_ADDR_SIZE,
    parameter int MEM_ADDR_SIZE  = c_DEF_MEM_ADDR,   // <= SRAM_ADDR_SIZE
    parameter int READ_LAT       = c_DEF_READ_LAT    // 1..7
) (
    input  logic                      clk,
    input  logic                      rst,
    inout  wire  [SRAM_DATA_SIZE-1:0] SRAM_DQ,
    input  logic [SRAM_ADDR_SIZE-1:0] SRAM_ADDR,
    input  logic                      SRAM_CE_N,
    input  logic                      SRAM_OE_N,
    input  logic                      SRAM_WE_N,
    input  logic                      SRAM_UB_N,
    input  logic                      SRAM_LB_N,
    input  logic                      fault_en,
    input  logic [MEM_ADDR_SIZE-1:0]  fault_addr,
    input  logic [SRAM_DATA_SIZE-1:0] fault_mask,
    output logic [15:0]               wr_count,
    output logic [15:0]               rd_count,
    output logic                      busy
);

    localparam logic [c_LAT_W-1:0] c_LAT_LOAD = c_LAT_W'(READ_LAT - 1);

    // Registered copies of the pins; all decisions use these
    logic                      r_s_ce;
    logic                      r_s_oe;
    logic                      r_s_we;
    logic [SRAM_ADDR_SIZE-1:0] r_s_addr;
    logic [SRAM_DATA_SIZE-1:0] r_s_dq;

    logic [c_ST_W-1:0]         r_state;
    logic [c_LAT_W-1:0]        r_lat;
    logic                      r_drive;
    logic [SRAM_ADDR_SIZE-1:0] r_rd_addr;
    logic [MEM_ADDR_SIZE-1:0]  r_wr_addr;
    logic [SRAM_DATA_SIZE-1:0] r_wr_data;
    logic [15:0]               r_wr_count;
    logic [15:0]               r_rd_count;

    logic                      w_commit;
    logic                      w_rd_abort;
    logic                      w_addr_chg;
    logic [MEM_ADDR_SIZE-1:0]  w_mem_addr;
    logic [SRAM_DATA_SIZE-1:0] w_mem_rdata;
    logic                      w_fault_hit;
    logic [SRAM_DATA_SIZE-1:0] w_rd_data;
    logic                      w_unused_lanes;

    assign w_unused_lanes = SRAM_UB_N ^ SRAM_LB_N;

    // Gated by rst so a write interrupted by reset never reaches the RAM
    assign w_commit   = !rst && (r_state == c_ST_WRITE_ACT) && (r_s_we || r_s_ce);
    assign w_rd_abort = r_s_oe || r_s_ce || !r_s_we;
    assign w_addr_chg = (r_s_addr != r_rd_addr);

    // The RAM port follows the write holding address only while a write is
    // open; otherwise it keeps reading the latched read address.
    assign w_mem_addr = (r_state == c_ST_WRITE_ACT) ? r_wr_addr
                                                    : r_rd_addr[MEM_ADDR_SIZE-1:0];

    sram_emu_mem #(
        .DATA_W (SRAM_DATA_SIZE),
        .ADDR_W (MEM_ADDR_SIZE)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_commit),
        .i_addr  (w_mem_addr),
        .i_wdata (r_wr_data),
        .o_rdata (w_mem_rdata)
    );

    // Fault controls act live on the data being driven
    assign w_fault_hit = fault_en && (r_rd_addr[MEM_ADDR_SIZE-1:0] == fault_addr);
    assign w_rd_data   = w_mem_rdata ^ (w_fault_hit ? fault_mask : '0);
    assign SRAM_DQ     = (r_drive == c_DQ_DRIVE) ? w_rd_data : {SRAM_DATA_SIZE{1'bz}};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s_ce     <= 1'b1;
            r_s_oe     <= 1'b1;
            r_s_we     <= 1'b1;
            r_s_addr   <= '0;
            r_s_dq     <= '0;
            r_state    <= c_ST_IDLE;
            r_lat      <= '0;
            r_drive    <= c_DQ_RELEASE;
            r_wr_count <= '0;
            r_rd_count <= '0;
        end else begin
            r_s_ce   <= SRAM_CE_N;
            r_s_oe   <= SRAM_OE_N;
            r_s_we   <= SRAM_WE_N;
            r_s_addr <= SRAM_ADDR;
            r_s_dq   <= SRAM_DQ;

            case (r_state)
                c_ST_IDLE: begin
                    // WE wins over OE
                    if (!r_s_ce && !r_s_we) begin
                        r_state   <= c_ST_WRITE_ACT;
                        r_wr_addr <= r_s_addr[MEM_ADDR_SIZE-1:0];
                        r_wr_data <= r_s_dq;
                    end else if (!r_s_ce && !r_s_oe) begin
                        r_state   <= c_ST_READ_WAIT;
                        r_lat     <= c_LAT_LOAD;
                        r_rd_addr <= r_s_addr;
                    end
                end

                c_ST_WRITE_ACT: begin
                    // Commit uses the data captured on the last WE-low cycle
                    if (r_s_we || r_s_ce) begin
                        r_wr_count <= r_wr_count + 16'd1;
                        r_state    <= c_ST_IDLE;
                    end else begin
                        r_wr_addr <= r_s_addr[MEM_ADDR_SIZE-1:0];
                        r_wr_data <= r_s_dq;
                    end
                end

                c_ST_READ_WAIT: begin
                    if (w_rd_abort) begin
                        r_state <= c_ST_IDLE;
                    end else if (w_addr_chg) begin
                        r_lat     <= c_LAT_LOAD;
                        r_rd_addr <= r_s_addr;
                    end else if (r_lat == '0) begin
                        r_state    <= c_ST_READ_DRIVE;
                        r_drive    <= c_DQ_DRIVE;
                        r_rd_count <= r_rd_count + 16'd1;
                    end else begin
                        r_lat <= r_lat - c_LAT_W'(1);
                    end
                end

                c_ST_READ_DRIVE: begin
                    if (w_rd_abort) begin
                        r_state <= c_ST_IDLE;
                        r_drive <= c_DQ_RELEASE;
                    end else if (w_addr_chg) begin
                        r_state   <= c_ST_READ_WAIT;
                        r_drive   <= c_DQ_RELEASE;
                        r_lat     <= c_LAT_LOAD;
                        r_rd_addr <= r_s_addr;
                    end
                end

                default: begin
                    r_state <= c_ST_IDLE;
                    r_drive <= c_DQ_RELEASE;
                end
            endcase
        end
    end

    assign wr_count = r_wr_count;
    assign rd_count = r_rd_count;
    assign busy     = (r_state != c_ST_IDLE);

endmodule : sram_emu
`default_nettype wire
